sop_sweep_ctrl: RTL and testbench
=================================

SOP_SWEEP_CTRL -- requirements
Module: sop_sweep_ctrl

Interface
REQ-001 Parameter SETTLE, default 1, settle cycles per vector before sampling; legal range 1..15.
REQ-002 Parameter USE_INT, default 1: 1 samples the internal sop_eval output, 0 samples s_in.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  sweep request, sampled on clk.
REQ-007 abort  input  1  synchronous cancel of a running sweep.
REQ-008 expected  input  16  golden minterm mask; bit i is the expected f at vector i.
REQ-009 s_in  input  1  response of the external 4-input function under test.
REQ-010 a, b, c, d  output  1 each  vector drive; {a,b,c,d} = idx, with a as MSB.
REQ-011 busy  output  1  high in APPLY and SAMPLE.
REQ-012 done  output  1  one-cycle pulse at sweep completion.
REQ-013 pass  output  1  result == expected; valid while in DONE and IDLE after a sweep.
REQ-014 result  output  16  captured truth table.
REQ-015 err_cnt  output  5  number of mismatching vectors (0..16).
REQ-016 first_fail  output  4  lowest mismatching index; 0 when err_cnt == 0.

Function
REQ-017 FSM states: IDLE, APPLY, SAMPLE, DONE.
REQ-018 IDLE: start=1 -> APPLY; idx, result, err_cnt, first_fail and the settle counter clear to 0; expected is latched.
REQ-019 APPLY: drives idx onto a..d; stays SETTLE cycles; the settle counter is 4 bits.
REQ-020 SAMPLE: result[idx] <= sample; a mismatch against latched expected[idx] increments err_cnt and, on the first mismatch, sets first_fail = idx.
REQ-021 SAMPLE with idx==15 -> DONE; otherwise idx <= idx+1 -> APPLY. idx does not wrap past 15.
REQ-022 Each vector takes SETTLE+1 cycles; DONE is entered 16*(SETTLE+1) cycles after the start edge.
REQ-023 DONE: done=1 and pass valid for exactly one cycle, then -> IDLE; result, err_cnt, first_fail and pass hold until the next accepted start.
REQ-024 start is ignored while busy=1; start asserted in DONE is accepted on the following IDLE cycle.
REQ-025 abort=1 in APPLY or SAMPLE -> IDLE next cycle; no done pulse; pass=0; captured data is left partial.
REQ-026 abort and start asserted together in IDLE: start wins; abort has no effect in IDLE or DONE.
REQ-027 a..d are 0 in IDLE and DONE.
REQ-028 pass = (err_cnt == 0) after a completed sweep.
REQ-029 The expected input may change mid-sweep without effect, because it is latched at start.

Reset
REQ-030 rst_n low forces IDLE and clears idx, the settle counter, a..d, busy, done, pass, result, err_cnt and first_fail to 0, from any state including mid-sweep.
REQ-031 The first start after rst_n deasserts is accepted on the first clk edge.

Structure
REQ-032 A shared package sop_pkg holds the state typedef (IDLE/APPLY/SAMPLE/DONE), VEC_N=16, IDX_W=4 and the golden mask SOP_MASK=16'hAC3C.
REQ-033 One combinational sub-module, sop_eval (ports s, a, b, c, d), implements f = ~a&b&~c | a&b&d | ~b&c and is instantiated inside sop_sweep_ctrl.

Verification
REQ-034 USE_INT=1, SETTLE=1, expected=16'hAC3C, start pulse -> done 32 cycles after start, result=16'hAC3C, pass=1, err_cnt=0.
REQ-035 USE_INT=1, expected=16'hAC3D -> pass=0, err_cnt=1, first_fail=0; expected=16'h53C3 -> err_cnt=16, first_fail=0.
REQ-036 USE_INT=0, s_in tied 1, expected=16'hFFF0 -> err_cnt=4, first_fail=0, result=16'hFFFF.
REQ-037 SETTLE=3, abort asserted during vector 7 -> IDLE next cycle, no done pulse, pass=0; a new start then completes in 64 cycles with pass=1.
REQ-038 rst_n pulled low during vector 9 -> all outputs 0 asynchronously; start re-asserted during busy is ignored with no second sweep.
REQ-039 a..d are checked every APPLY cycle to equal idx, stepping 0..15 in order.

Source files
------------

// File: rtl/sop_pkg.sv
// Shared types and constants for the sum-of-products sweep controller.
package sop_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int unsigned VEC_N = 16;
    localparam int unsigned IDX_W = 4;

    // Golden truth table of f = ~a&b&~c | a&b&d | ~b&c, bit i = f({a,b,c,d} = i).
    localparam logic [VEC_N-1:0] SOP_MASK = 16'hAC3C;

endpackage

// File: rtl/sop_eval.sv
// Combinational reference implementation of the 4-input sum-of-products function.
module sop_eval (
    output logic s,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d
);

    assign s = (~a & b & ~c) | (a & b & d) | (~b & c);

endmodule

// File: rtl/sop_sweep_ctrl.sv
// Exhaustive 16-vector sweep of a 4-input function, compared against a latched golden mask.
module sop_sweep_ctrl
    import sop_pkg::*;
#(
    parameter int unsigned SETTLE  = 1,
    parameter bit          USE_INT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [VEC_N-1:0] expected,
    input  logic             s_in,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [VEC_N-1:0] result,
    output logic [4:0]       err_cnt,
    output logic [IDX_W-1:0] first_fail
);

    localparam logic [3:0] SET_LAST = 4'(SETTLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VEC_N - 1);

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [3:0]       set_q;
    logic [IDX_W-1:0] drv_q;
    logic [VEC_N-1:0] exp_q;
    logic [VEC_N-1:0] result_q;
    logic [4:0]       err_q;
    logic [IDX_W-1:0] ff_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             pend_q;

    logic             f_int;
    logic             sample;
    logic             mism;
    logic [4:0]       err_d;

    sop_eval u_eval (
        .s (f_int),
        .a (drv_q[3]),
        .b (drv_q[2]),
        .c (drv_q[1]),
        .d (drv_q[0])
    );

    always_comb begin
        sample = USE_INT ? f_int : s_in;
        mism   = sample ^ exp_q[idx_q];
        err_d  = err_q + 5'(mism);
    end

    // A start seen in DONE is parked in pend_q and taken on the next IDLE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            set_q    <= '0;
            drv_q    <= '0;
            exp_q    <= '0;
            result_q <= '0;
            err_q    <= '0;
            ff_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start || pend_q) begin
                        state_q  <= APPLY;
                        idx_q    <= '0;
                        set_q    <= '0;
                        drv_q    <= '0;
                        exp_q    <= expected;
                        result_q <= '0;
                        err_q    <= '0;
                        ff_q     <= '0;
                        pass_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        pend_q   <= 1'b0;
                    end
                end
                APPLY: begin
                    if (abort) begin
                        state_q <= IDLE;
                        set_q   <= '0;
                        drv_q   <= '0;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else if (set_q == SET_LAST) begin
                        state_q <= SAMPLE;
                    end else begin
                        set_q <= set_q + 4'd1;
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        state_q <= IDLE;
                        set_q   <= '0;
                        drv_q   <= '0;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else begin
                        result_q[idx_q] <= sample;
                        err_q           <= err_d;
                        if (mism && (err_q == '0)) begin
                            ff_q <= idx_q;
                        end
                        set_q <= '0;
                        if (idx_q == IDX_LAST) begin
                            state_q <= DONE;
                            drv_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == '0);
                        end else begin
                            state_q <= APPLY;
                            idx_q   <= idx_q + 1'b1;
                            drv_q   <= idx_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    pend_q  <= start;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign {a, b, c, d} = drv_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign result       = result_q;
    assign err_cnt      = err_q;
    assign first_fail   = ff_q;

endmodule

// File: tb/tb_sop_sweep_ctrl.sv
// Directed bench for sop_sweep_ctrl: three instances cover SETTLE=1/3 and internal/external sampling.
module tb_sop_sweep_ctrl;
    import sop_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       start_w;
    logic             abort;
    logic [15:0]      expected;

    logic [2:0][3:0]  abcd_w;
    logic [2:0]       busy_w;
    logic [2:0]       done_w;
    logic [2:0]       pass_w;
    logic [2:0][15:0] res_w;
    logic [2:0][4:0]  err_w;
    logic [2:0][3:0]  ff_w;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sop_sweep_ctrl #(.SETTLE(1), .USE_INT(1'b1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start_w[0]), .abort(abort),
        .expected(expected), .s_in(1'b0),
        .a(abcd_w[0][3]), .b(abcd_w[0][2]), .c(abcd_w[0][1]), .d(abcd_w[0][0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .result(res_w[0]), .err_cnt(err_w[0]), .first_fail(ff_w[0])
    );

    sop_sweep_ctrl #(.SETTLE(3), .USE_INT(1'b1)) u_s3 (
        .clk(clk), .rst_n(rst_n), .start(start_w[1]), .abort(abort),
        .expected(expected), .s_in(1'b0),
        .a(abcd_w[1][3]), .b(abcd_w[1][2]), .c(abcd_w[1][1]), .d(abcd_w[1][0]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .result(res_w[1]), .err_cnt(err_w[1]), .first_fail(ff_w[1])
    );

    sop_sweep_ctrl #(.SETTLE(1), .USE_INT(1'b0)) u_ext (
        .clk(clk), .rst_n(rst_n), .start(start_w[2]), .abort(abort),
        .expected(expected), .s_in(1'b1),
        .a(abcd_w[2][3]), .b(abcd_w[2][2]), .c(abcd_w[2][1]), .d(abcd_w[2][0]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .result(res_w[2]), .err_cnt(err_w[2]), .first_fail(ff_w[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One sweep on instance k; abort_vec >= 0 cancels during that vector's first APPLY cycle.
    task automatic sweep(input int k, input logic [15:0] em, input bit with_abort,
                         input int extra_start_j, input int abort_vec, input bit restart,
                         input logic [15:0] x_res, input int x_err, input int x_ff, input bit x_pass);
        int  s;
        bit  seen;
        s    = (k == 1) ? 3 : 1;
        seen = 1'b0;
        expected = em;
        @(negedge clk);
        start_w[k] = 1'b1;
        abort      = with_abort;
        @(negedge clk);
        start_w[k] = 1'b0;
        abort      = 1'b0;
        for (int j = 0; j < 300; j++) begin
            if (j == 5) expected = ~em;
            start_w[k] = (j == extra_start_j);
            if (done_w[k]) begin
                seen = 1'b1;
                chk("done_latency", j, 16 * (s + 1));
                chk("result", res_w[k], x_res);
                chk("err_cnt", err_w[k], x_err);
                chk("first_fail", ff_w[k], x_ff);
                chk("pass_in_done", pass_w[k], x_pass);
                chk("abcd_done", abcd_w[k], 0);
                start_w[k] = restart;
                @(negedge clk);
                start_w[k] = 1'b0;
                chk("done_one_cycle", done_w[k], 0);
                chk("busy_idle", busy_w[k], 0);
                chk("pass_hold", pass_w[k], x_pass);
                chk("result_hold", res_w[k], x_res);
                chk("err_hold", err_w[k], x_err);
                if (restart) begin
                    @(negedge clk);
                    chk("start_in_done_accepted", busy_w[k], 1);
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    chk("abort_after_restart", busy_w[k], 0);
                end else begin
                    for (int i = 0; i < 3; i++) begin
                        @(negedge clk);
                        chk("no_second_sweep", busy_w[k], 0);
                    end
                end
                break;
            end
            if ((j % (s + 1)) < s) chk("abcd_apply", abcd_w[k], j / (s + 1));
            if (abort_vec >= 0 && j == abort_vec * (s + 1)) begin
                seen  = 1'b1;
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk("abort_busy", busy_w[k], 0);
                chk("abort_pass", pass_w[k], 0);
                chk("abort_abcd", abcd_w[k], 0);
                for (int i = 0; i < 2 * (s + 1); i++) begin
                    chk("abort_no_done", done_w[k], 0);
                    @(negedge clk);
                end
                break;
            end
            @(negedge clk);
        end
        start_w[k] = 1'b0;
        chk("sweep_completed_in_budget", seen, 1);
    endtask

    initial begin
        rst_n    = 1'b0;
        start_w  = '0;
        abort    = 1'b0;
        expected = '0;
        #12;
        chk("rst_busy", busy_w, 0);
        chk("rst_done", done_w, 0);
        chk("rst_pass", pass_w, 0);
        chk("rst_abcd", abcd_w[0], 0);
        chk("rst_result", res_w[0], 0);
        chk("rst_err", err_w[0], 0);
        chk("rst_ff", ff_w[0], 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Golden pass; abort together with start; extra start while busy ignored.
        sweep(0, SOP_MASK, 1'b1, 10, -1, 1'b0, 16'hAC3C, 0, 0, 1'b1);
        sweep(0, 16'hAC3D, 1'b0, -1, -1, 1'b0, 16'hAC3C, 1, 0, 1'b0);
        sweep(0, 16'h53C3, 1'b0, -1, -1, 1'b0, 16'hAC3C, 16, 0, 1'b0);
        sweep(0, 16'hAC38, 1'b0, -1, -1, 1'b0, 16'hAC3C, 1, 2, 1'b0);
        sweep(0, 16'h2C3C, 1'b0, -1, -1, 1'b1, 16'hAC3C, 1, 15, 1'b0);

        // External sampling with s_in tied high.
        sweep(2, 16'hFFF0, 1'b0, -1, -1, 1'b0, 16'hFFFF, 4, 0, 1'b0);

        // SETTLE=3: pass, abort in vector 7, then a clean sweep.
        sweep(1, SOP_MASK, 1'b0, -1, -1, 1'b0, 16'hAC3C, 0, 0, 1'b1);
        sweep(1, SOP_MASK, 1'b0, -1, 7, 1'b0, 16'h0000, 0, 0, 1'b0);
        sweep(1, SOP_MASK, 1'b0, 20, -1, 1'b0, 16'hAC3C, 0, 0, 1'b1);

        // Asynchronous reset during vector 9.
        expected = SOP_MASK;
        @(negedge clk);
        start_w[0] = 1'b1;
        @(negedge clk);
        start_w[0] = 1'b0;
        repeat (18) @(negedge clk);
        chk("pre_reset_abcd", abcd_w[0], 9);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_abcd", abcd_w[0], 0);
        chk("arst_busy", busy_w[0], 0);
        chk("arst_done", done_w[0], 0);
        chk("arst_pass", pass_w[0], 0);
        chk("arst_result", res_w[0], 0);
        chk("arst_err", err_w[0], 0);
        chk("arst_ff", ff_w[0], 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        sweep(0, SOP_MASK, 1'b0, -1, -1, 1'b0, 16'hAC3C, 0, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
